// File: rtl/uart_rd_ctrl.sv
// rtl/uart_rd_ctrl.sv - drains the UART receive FIFO and packs bytes little-endian into host words.
// Optional idle-timeout flush of partial words is enabled by defining UART_RD_TIMEOUT_EN.
module uart_rd_ctrl #(
  parameter int UART_FIFO_WIDTH = 8,
  parameter int WORD_BYTES      = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  rd_f_empty,
  output logic                                  rd_fifo_en,
  input  logic [UART_FIFO_WIDTH-1:0]            rd_fifo_data,
  input  logic                                  flush,
  output logic                                  word_valid,
  input  logic                                  word_ready,
  output logic [UART_FIFO_WIDTH*WORD_BYTES-1:0] word_data,
  output logic [WORD_BYTES-1:0]                 word_keep
);

  localparam int CW = $clog2(WORD_BYTES + 1);

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_CAPT = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  logic [1:0]                            state;
  logic [1:0]                            state_nxt;
  logic [CW-1:0]                         byte_cnt;
  logic [UART_FIFO_WIDTH*WORD_BYTES-1:0] data_q;
  logic [WORD_BYTES-1:0]                 keep_q;
  logic                                  has_bytes;
  logic                                  flush_go;
  logic                                  timeout_go;
  logic                                  read_go;

  assign has_bytes = (byte_cnt != '0);
  // A flush of a non-empty word wins over starting another FIFO read.
  assign flush_go  = (state == ST_FILL) && flush && has_bytes;
  assign read_go   = (state == ST_FILL) && !rd_f_empty && !flush_go && !timeout_go;

`ifdef UART_RD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] tmo_cnt;

  assign timeout_go = (state == ST_FILL) && has_bytes && rd_f_empty &&
                      (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state != ST_FILL || timeout_go || flush_go) begin
      tmo_cnt <= '0;
    end else if (has_bytes && rd_f_empty) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
`else
  assign timeout_go = 1'b0;
`endif

  assign rd_fifo_en = rst_n && read_go;
  assign word_valid = (state == ST_SEND);
  assign word_data  = data_q;
  assign word_keep  = keep_q;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FILL: begin
        if (flush_go || timeout_go) begin
          state_nxt = ST_SEND;
        end else if (read_go) begin
          state_nxt = ST_CAPT;
        end
      end
      ST_CAPT: begin
        if (byte_cnt == CW'(WORD_BYTES - 1) || flush) begin
          state_nxt = ST_SEND;
        end else begin
          state_nxt = ST_FILL;
        end
      end
      ST_SEND: begin
        if (word_ready) begin
          state_nxt = ST_FILL;
        end
      end
      default: state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_FILL;
      byte_cnt <= '0;
      data_q   <= '0;
      keep_q   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_CAPT) begin
        for (int k = 0; k < WORD_BYTES; k++) begin
          if (byte_cnt == CW'(k)) begin
            data_q[k*UART_FIFO_WIDTH +: UART_FIFO_WIDTH] <= rd_fifo_data;
            keep_q[k]                                    <= 1'b1;
          end
        end
        byte_cnt <= byte_cnt + CW'(1);
      end else if (state == ST_SEND && word_ready) begin
        // Clearing here keeps unused lanes at zero for the next partial word.
        byte_cnt <= '0;
        data_q   <= '0;
        keep_q   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rd_ctrl.sv
// tb/tb_uart_rd_ctrl.sv - directed self-checking bench for uart_rd_ctrl with a behavioural FIFO.
module tb_uart_rd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_f_empty;
  logic        rd_fifo_en;
  logic [7:0]  rd_fifo_data = 8'h00;
  logic        flush = 1'b0;
  logic        word_valid;
  logic        word_ready = 1'b1;
  logic [31:0] word_data;
  logic [3:0]  word_keep;

  uart_rd_ctrl #(
    .UART_FIFO_WIDTH(8),
    .WORD_BYTES(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rd_f_empty(rd_f_empty),
    .rd_fifo_en(rd_fifo_en),
    .rd_fifo_data(rd_fifo_data),
    .flush(flush),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .word_data(word_data),
    .word_keep(word_keep)
  );

  always #5 clk = ~clk;

  // FIFO model: data appears the cycle after the read strobe.
  logic [7:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign rd_f_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (rd_fifo_en) begin
      rd_fifo_data <= mem[rd_ptr[7:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_no = 0;
  int en_cnt, b2b, hs_cnt, valid_cnt, last_en_cyc, first_valid_cyc;
  logic prev_en, prev_valid;
  logic [31:0] hs_data;
  logic [3:0]  hs_keep;

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[7:0]] = b;
    wr_ptr++;
  endtask

  task automatic clr_stats;
    en_cnt = 0; b2b = 0; hs_cnt = 0; valid_cnt = 0;
    last_en_cyc = -1; first_valid_cyc = -1;
    prev_en = 1'b0; prev_valid = 1'b0;
    hs_data = 32'h0; hs_keep = 4'h0;
  endtask

  // Sample at the falling edge, then step through the rising edge.
  task automatic cyc;
    #4;
    if (rd_fifo_en) begin
      en_cnt++;
      last_en_cyc = cyc_no;
      if (prev_en) b2b++;
    end
    if (word_valid) begin
      valid_cnt++;
      if (!prev_valid && first_valid_cyc < 0) first_valid_cyc = cyc_no;
    end
    if (word_valid && word_ready) begin
      hs_cnt++;
      hs_data = word_data;
      hs_keep = word_keep;
    end
    prev_en = rd_fifo_en;
    prev_valid = word_valid;
    cyc_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    push(8'h11);
    @(posedge clk);
    #1;
    n_cmp++; if (rd_fifo_en !== 1'b0) begin n_bad++; $display("FAIL reset_en: got %b want 0", rd_fifo_en); end
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", word_valid); end
    n_cmp++; if (word_data !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h want 00000000", word_data); end
    n_cmp++; if (word_keep !== 4'h0) begin n_bad++; $display("FAIL reset_keep: got %b want 0000", word_keep); end
    rst_n = 1'b1;
  endtask

  task automatic test_full_word;
    push(8'h22); push(8'h33); push(8'h44);
    word_ready = 1'b1;
    clr_stats();
    repeat (14) cyc();
    n_cmp++; if (hs_cnt !== 1) begin n_bad++; $display("FAIL full_hs_cnt: got %0d want 1", hs_cnt); end
    n_cmp++; if (hs_data !== 32'h44332211) begin n_bad++; $display("FAIL full_data: got %h want 44332211", hs_data); end
    n_cmp++; if (hs_keep !== 4'b1111) begin n_bad++; $display("FAIL full_keep: got %b want 1111", hs_keep); end
    n_cmp++; if (en_cnt !== 4) begin n_bad++; $display("FAIL full_en_cnt: got %0d want 4", en_cnt); end
    n_cmp++; if (b2b !== 0) begin n_bad++; $display("FAIL full_en_b2b: got %0d want 0", b2b); end
    n_cmp++; if (first_valid_cyc - last_en_cyc !== 2) begin n_bad++; $display("FAIL full_latency: got %0d want 2", first_valid_cyc - last_en_cyc); end
  endtask

  task automatic test_backpressure;
    int stall_bad;
    stall_bad = 0;
    for (int i = 1; i <= 8; i++) push(8'(i * 8'h11));
    word_ready = 1'b0;
    clr_stats();
    repeat (10) cyc();
    n_cmp++; if (en_cnt !== 4) begin n_bad++; $display("FAIL bp_first_reads: got %0d want 4", en_cnt); end
    clr_stats();
    for (int i = 0; i < 50; i++) begin
      if (word_valid !== 1'b1 || word_data !== 32'h44332211 || word_keep !== 4'hF) stall_bad++;
      cyc();
    end
    n_cmp++; if (stall_bad !== 0) begin n_bad++; $display("FAIL bp_stable: got %0d bad cycles want 0", stall_bad); end
    n_cmp++; if (en_cnt !== 0) begin n_bad++; $display("FAIL bp_no_read: got %0d reads want 0", en_cnt); end
    n_cmp++; if (wr_ptr - rd_ptr !== 4) begin n_bad++; $display("FAIL bp_fifo_level: got %0d want 4", wr_ptr - rd_ptr); end
    word_ready = 1'b1;
    clr_stats();
    repeat (14) cyc();
    n_cmp++; if (hs_cnt !== 2) begin n_bad++; $display("FAIL bp_hs_cnt: got %0d want 2", hs_cnt); end
    n_cmp++; if (hs_data !== 32'h88776655) begin n_bad++; $display("FAIL bp_second: got %h want 88776655", hs_data); end
  endtask

  task automatic test_flush_partial;
    push(8'hA5); push(8'h5A);
    clr_stats();
    repeat (6) cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    repeat (4) cyc();
    n_cmp++; if (hs_cnt !== 1) begin n_bad++; $display("FAIL flush_hs_cnt: got %0d want 1", hs_cnt); end
    n_cmp++; if (hs_data !== 32'h00005AA5) begin n_bad++; $display("FAIL flush_data: got %h want 00005aa5", hs_data); end
    n_cmp++; if (hs_keep !== 4'b0011) begin n_bad++; $display("FAIL flush_keep: got %b want 0011", hs_keep); end
    clr_stats();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    repeat (5) cyc();
    n_cmp++; if (valid_cnt !== 0) begin n_bad++; $display("FAIL flush_empty: got %0d valid cycles want 0", valid_cnt); end
  endtask

  task automatic test_timeout;
    push(8'h7E);
    clr_stats();
`ifdef UART_RD_TIMEOUT_EN
    for (int i = 0; i < 60 && hs_cnt == 0; i++) cyc();
    n_cmp++; if (hs_cnt !== 1) begin n_bad++; $display("FAIL tmo_hs_cnt: got %0d want 1", hs_cnt); end
    n_cmp++; if (first_valid_cyc - last_en_cyc - 2 < 15 || first_valid_cyc - last_en_cyc - 2 > 17) begin
      n_bad++; $display("FAIL tmo_delay: got %0d want 16+-1", first_valid_cyc - last_en_cyc - 2);
    end
    n_cmp++; if (hs_keep !== 4'b0001) begin n_bad++; $display("FAIL tmo_keep: got %b want 0001", hs_keep); end
    n_cmp++; if (hs_data !== 32'h0000007E) begin n_bad++; $display("FAIL tmo_data: got %h want 0000007e", hs_data); end
`else
    repeat (1000) cyc();
    n_cmp++; if (valid_cnt !== 0) begin n_bad++; $display("FAIL notmo_valid: got %0d valid cycles want 0", valid_cnt); end
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    repeat (3) cyc();
    n_cmp++; if (hs_data !== 32'h0000007E || hs_keep !== 4'b0001) begin
      n_bad++; $display("FAIL notmo_drain: got %h/%b want 0000007e/0001", hs_data, hs_keep);
    end
`endif
  endtask

  task automatic test_reset_mid_word;
    push(8'h01); push(8'h02);
    clr_stats();
    repeat (4) cyc();
    n_cmp++; if (word_data !== 32'h00000201) begin n_bad++; $display("FAIL rst_mid_pre: got %h want 00000201", word_data); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (word_data !== 32'h0 || word_keep !== 4'h0) begin
      n_bad++; $display("FAIL rst_mid_clear: got %h/%b want 0/0", word_data, word_keep);
    end
    n_cmp++; if (word_valid !== 1'b0 || rd_fifo_en !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_ctl: got valid %b en %b want 0 0", word_valid, rd_fifo_en);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
    clr_stats();
    repeat (14) cyc();
    n_cmp++; if (hs_cnt !== 1 || hs_data !== 32'hD4C3B2A1 || hs_keep !== 4'hF) begin
      n_bad++; $display("FAIL rst_mid_fresh: got %0d %h %b want 1 d4c3b2a1 1111", hs_cnt, hs_data, hs_keep);
    end
  endtask

  task automatic test_flush_capt;
    push(8'h10); push(8'h20); push(8'h30);
    clr_stats();
    repeat (5) cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    repeat (4) cyc();
    n_cmp++; if (hs_cnt !== 1) begin n_bad++; $display("FAIL fcapt_hs_cnt: got %0d want 1", hs_cnt); end
    n_cmp++; if (hs_keep !== 4'b0111) begin n_bad++; $display("FAIL fcapt_keep: got %b want 0111", hs_keep); end
    n_cmp++; if (hs_data !== 32'h00302010) begin n_bad++; $display("FAIL fcapt_data: got %h want 00302010", hs_data); end
  endtask

  initial begin
    clr_stats();
    test_reset();
    test_full_word();
    test_backpressure();
    test_flush_partial();
    test_timeout();
    test_reset_mid_word();
    test_flush_capt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
